decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  in  1  fetch offers an instruction word.
REQ-005 SHALL have port in_ready  out  1  queue accepts the word this cycle.
REQ-006 SHALL have port in_inst  in  32  raw instruction word.
REQ-007 SHALL have port flush  in  1  synchronous discard of all queued entries.
REQ-008 SHALL have port iss_enable  out  1  head entry valid toward RS.
REQ-009 SHALL have port iss_ack  in  1  RS takes head entry.
REQ-010 SHALL have ports iss_unit  out  3, iss_reg1/iss_reg2/iss_reg3  out  6 each, iss_hasimm  out  1, iss_imm  out  32 signed: decoded head entry.
REQ-011 SHALL have port halted  out  1  sticky, halt instruction has been accepted.
REQ-012 SHALL have port drop_err  out  1  one-cycle pulse, accepted opcode not RS-bound.

Function
REQ-013 Input transfer SHALL occur on in_valid && in_ready; in_ready = !full && !halted.
REQ-014 Decode fields: opcode [31:28], reg1 [27:22], reg2 [21:16], reg3 [15:10], imm flag [0].
REQ-015 Unit map: 1100->000 lw, 1101->001 sw, 1000->010 add, 1001->011 mul, 1111->100 mv, 0001->101 halt.
REQ-016 iss_imm: sign-extended [15:1] for lw/sw/add/mul, sign-extended [21:1] for mv; iss_hasimm = bit[0]; halt entry has hasimm=0, imm=0.
REQ-017 Opcode 0000 (empty slot) SHALL be accepted and discarded without entry, no error.
REQ-018 Opcodes 1010, 1011, 1110 and all others unmapped SHALL be accepted, discarded, drop_err pulsed next cycle.
REQ-019 Accepted halt SHALL be enqueued and set halted on the same edge; halted holds until reset.
REQ-020 Non-bypass latency: word accepted at edge N into empty queue -> iss_enable high in cycle N+1.
REQ-021 iss_enable = queue non-empty; iss_* SHALL hold stable while iss_enable && !iss_ack.
REQ-022 Head retired on iss_enable && iss_ack; next entry presented in following cycle.
REQ-023 Simultaneous push and pop when not full SHALL keep count unchanged; when full, push is blocked (no pop-through).
REQ-024 Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-025 flush SHALL empty queue and outrank same-cycle push and pop; halted unaffected.

Reset
REQ-026 rst_n low SHALL asynchronously clear pointers/count, halted=0, drop_err=0, iss_enable=0, in_ready=0 during reset.
REQ-027 iss_* data outputs SHALL read 0 while empty and during reset.
REQ-028 Reset mid-handshake SHALL discard all entries; no retire counted.

Configuration
REQ-029 Macro DECODE_QUEUE_BYPASS_EN defined: empty queue with accepted RS-bound word SHALL drive iss_enable and decoded fields combinationally same cycle; iss_ack same cycle consumes it without enqueue.
REQ-030 Macro undefined: no bypass; REQ-020 latency applies always.

Structure
REQ-031 Shared package SHALL hold opcode constants, unit codes (UNIT_LW..UNIT_HALT), field widths (WORD_SIZE 32, REG_SIZE 6) and the decoded-entry struct typedef.
REQ-032 Pure combinational sub-module inst_decoder SHALL map word -> entry + rs_bound + drop flags; queue storage stays in decode_queue.

Verification
REQ-033 Reset, push 0x8084_0003 (add r2,r4,imm 1) -> next cycle iss_enable=1, unit=010, reg1=2, reg2=4, hasimm=1, imm=1.
REQ-034 Push DEPTH lw words with iss_ack=0 -> in_ready=0 after 4th; ack one -> in_ready=1 next cycle; order preserved.
REQ-035 Push 0x0000_0000 then 0xE000_0010 -> no entry, drop_err pulses once only for second.
REQ-036 Push 0x1000_0000 -> unit=101 issued, halted=1, in_ready stays 0 for further in_valid.
REQ-037 Three entries queued, flush with in_valid and iss_ack high -> next cycle iss_enable=0, count 0.
REQ-038 With DECODE_QUEUE_BYPASS_EN, empty queue, push mul + iss_ack same cycle -> iss_enable=1 that cycle, queue remains empty.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared decode-queue types: opcode and unit encodings, field widths, decoded entry.
// Latency: none, declarations only.
// Backpressure: not applicable.
package decode_queue_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_SIZE  = 6;
    localparam int UNIT_SIZE = 3;

    localparam logic [3:0] OP_EMPTY = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MV    = 4'b1111;
    localparam logic [3:0] OP_HALT  = 4'b0001;

    localparam logic [UNIT_SIZE-1:0] UNIT_LW   = 3'b000;
    localparam logic [UNIT_SIZE-1:0] UNIT_SW   = 3'b001;
    localparam logic [UNIT_SIZE-1:0] UNIT_ADD  = 3'b010;
    localparam logic [UNIT_SIZE-1:0] UNIT_MUL  = 3'b011;
    localparam logic [UNIT_SIZE-1:0] UNIT_MV   = 3'b100;
    localparam logic [UNIT_SIZE-1:0] UNIT_HALT = 3'b101;

    typedef struct packed {
        logic [UNIT_SIZE-1:0] unit;
        logic [REG_SIZE-1:0]  reg1;
        logic [REG_SIZE-1:0]  reg2;
        logic [REG_SIZE-1:0]  reg3;
        logic                 hasimm;
        logic [WORD_SIZE-1:0] imm;
    } entry_t;

endpackage

// File: rtl/inst_decoder.sv
// Instruction decoder: raw word to queue entry plus rs_bound/drop classification.
// Latency: purely combinational.
// Backpressure: none, the caller decides when the word is accepted.
module inst_decoder
    import decode_queue_pkg::*;
(
    input  logic [WORD_SIZE-1:0] inst,
    output entry_t               entry,
    output logic                 rs_bound,
    output logic                 drop
);

    logic [3:0]           opcode;
    logic [WORD_SIZE-1:0] imm_short;
    logic [WORD_SIZE-1:0] imm_long;

    assign opcode    = inst[31:28];
    assign imm_short = {{(WORD_SIZE-15){inst[15]}}, inst[15:1]};
    assign imm_long  = {{(WORD_SIZE-21){inst[21]}}, inst[21:1]};

    always_comb begin
        entry        = '0;
        entry.reg1   = inst[27:22];
        entry.reg2   = inst[21:16];
        entry.reg3   = inst[15:10];
        entry.hasimm = inst[0];
        entry.imm    = imm_short;
        rs_bound     = 1'b1;
        drop         = 1'b0;
        case (opcode)
            OP_LW:  entry.unit = UNIT_LW;
            OP_SW:  entry.unit = UNIT_SW;
            OP_ADD: entry.unit = UNIT_ADD;
            OP_MUL: entry.unit = UNIT_MUL;
            OP_MV: begin
                entry.unit = UNIT_MV;
                entry.imm  = imm_long;
            end
            OP_HALT: begin
                entry.unit   = UNIT_HALT;
                entry.hasimm = 1'b0;
                entry.imm    = '0;
            end
            // Empty slot: silently swallowed, not an error.
            OP_EMPTY: rs_bound = 1'b0;
            default: begin
                rs_bound = 1'b0;
                drop     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: decodes fetched words and buffers RS-bound entries for issue (DECODE_QUEUE_BYPASS_EN adds empty-queue bypass).
// Latency: issue the cycle after acceptance; same cycle via bypass when enabled and the queue is empty.
// Backpressure: in_ready low when full or halted (no pop-through); head holds until iss_ack.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_SIZE-1:0]        in_inst,
    input  logic                        flush,
    output logic                        iss_enable,
    input  logic                        iss_ack,
    output logic [UNIT_SIZE-1:0]        iss_unit,
    output logic [REG_SIZE-1:0]         iss_reg1,
    output logic [REG_SIZE-1:0]         iss_reg2,
    output logic [REG_SIZE-1:0]         iss_reg3,
    output logic                        iss_hasimm,
    output logic signed [WORD_SIZE-1:0] iss_imm,
    output logic                        halted,
    output logic                        drop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t        mem [DEPTH];
    entry_t        dec_entry;
    entry_t        head;
    logic          dec_rs_bound;
    logic          dec_drop;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          accept;
    logic          push_word;
    logic          bypass;
    logic          enq;
    logic          deq;

    inst_decoder u_dec (
        .inst     (in_inst),
        .entry    (dec_entry),
        .rs_bound (dec_rs_bound),
        .drop     (dec_drop)
    );

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    // rst_n term keeps in_ready low while reset is held.
    assign in_ready  = rst_n && !full && !halted;
    assign accept    = in_valid && in_ready;
    assign push_word = accept && dec_rs_bound;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypass = empty && push_word && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign iss_enable = !empty || bypass;
    assign deq        = iss_ack && !empty;
    assign enq        = push_word && !(bypass && iss_ack);

    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end else if (bypass) begin
            head = dec_entry;
        end
    end

    assign iss_unit   = head.unit;
    assign iss_reg1   = head.reg1;
    assign iss_reg2   = head.reg2;
    assign iss_reg3   = head.reg3;
    assign iss_hasimm = head.hasimm;
    assign iss_imm    = head.imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !flush) mem[wr_ptr] <= dec_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted   <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            if (push_word && dec_entry.unit == UNIT_HALT) halted <= 1'b1;
            drop_err <= accept && dec_drop;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic        flush = 1'b0;
    logic        iss_ack = 1'b0;
    logic        in_ready, iss_enable, iss_hasimm, halted, drop_err;
    logic [2:0]  iss_unit;
    logic [5:0]  iss_reg1, iss_reg2, iss_reg3;
    logic signed [31:0] iss_imm;
    logic [53:0] head_dat;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  unit;
        logic [5:0]  r1;
        logic [5:0]  r2;
        logic [5:0]  r3;
        logic        hi;
        logic [31:0] imm;
        bit          bound;
        bit          drop;
        bit          halt;
    } m_entry_t;

    m_entry_t m_q[$];
    bit       m_halted = 1'b0;
    bit       m_drop = 1'b0;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .flush(flush), .iss_enable(iss_enable), .iss_ack(iss_ack),
        .iss_unit(iss_unit), .iss_reg1(iss_reg1), .iss_reg2(iss_reg2), .iss_reg3(iss_reg3),
        .iss_hasimm(iss_hasimm), .iss_imm(iss_imm), .halted(halted), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    assign head_dat = {iss_unit, iss_reg1, iss_reg2, iss_reg3, iss_hasimm, iss_imm};

    // Reference decode computed from field arithmetic on the word.
    function automatic m_entry_t model_decode(input logic [31:0] w);
        m_entry_t e;
        int       op;
        int       f;
        e = '0;
        op = int'(w >> 28);
        e.r1 = 6'((w >> 22) % 64);
        e.r2 = 6'((w >> 16) % 64);
        e.r3 = 6'((w >> 10) % 64);
        e.hi = w[0];
        f = int'((w >> 1) % 32768);
        if (f >= 16384) f = f - 32768;
        e.imm = 32'(f);
        e.bound = 1'b1;
        case (op)
            12: e.unit = 3'd0;
            13: e.unit = 3'd1;
            8:  e.unit = 3'd2;
            9:  e.unit = 3'd3;
            15: begin
                e.unit = 3'd4;
                f = int'((w >> 1) % (1 << 21));
                if (f >= (1 << 20)) f = f - (1 << 21);
                e.imm = 32'(f);
            end
            1: begin
                e.unit = 3'd5;
                e.hi = 1'b0;
                e.imm = '0;
                e.halt = 1'b1;
            end
            0: e.bound = 1'b0;
            default: begin
                e.bound = 1'b0;
                e.drop = 1'b1;
            end
        endcase
        return e;
    endfunction

    function automatic logic [53:0] pack_e(input m_entry_t e);
        return {e.unit, e.r1, e.r2, e.r3, e.hi, e.imm};
    endfunction

    function automatic bit m_ready();
        return (m_q.size() < DEPTH) && !m_halted;
    endfunction

    function automatic bit m_bypass();
`ifdef DECODE_QUEUE_BYPASS_EN
        m_entry_t d;
        d = model_decode(in_inst);
        return (m_q.size() == 0) && in_valid && m_ready() && d.bound && !flush;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [53:0] exp_head();
        if (m_q.size() > 0) return pack_e(m_q[0]);
        if (m_bypass()) return pack_e(model_decode(in_inst));
        return '0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        logic [3:0]  op;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: op = 4'hC;
            1: op = 4'hD;
            2: op = 4'h8;
            3: op = 4'h9;
            4: op = 4'hF;
            5: op = 4'h0;
            6: op = 4'hA;
            7: op = 4'hB;
            8: op = 4'hE;
            default: op = 4'h3;
        endcase
        return {op, r[27:0]};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic drive(input logic v, input logic [31:0] w, input logic a, input logic f);
        in_valid = v;
        in_inst = w;
        iss_ack = a;
        flush = f;
        #2;
    endtask

    task automatic tick();
        m_entry_t d;
        m_entry_t dummy;
        bit acc, byp, pop, fl, ack;
        d = model_decode(in_inst);
        acc = in_valid && m_ready();
        byp = m_bypass();
        ack = iss_ack;
        pop = ack && (m_q.size() > 0);
        fl = flush;
        @(posedge clk);
        #1;
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop) dummy = m_q.pop_front();
            if (acc && d.bound && !(byp && ack)) m_q.push_back(d);
        end
        if (acc && d.halt) m_halted = 1'b1;
        m_drop = acc && d.drop;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 32'h8084_0003, 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL reset_iss_enable got %b exp 0", iss_enable); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err got %b exp 0", drop_err); end
        checks++; if (head_dat !== 54'd0) begin errors++; $display("FAIL reset_iss_data got %h exp 0", head_dat); end
        in_valid = 1'b0;
        iss_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_latency();
        drive(1'b1, 32'h8084_0003, 1'b0, 1'b0);
        checks++; if (iss_enable !== m_bypass()) begin errors++; $display("FAIL add_same_cycle_enable got %b exp %b", iss_enable, m_bypass()); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (iss_enable !== 1'b1) begin errors++; $display("FAIL add_enable got %b exp 1", iss_enable); end
        checks++; if (iss_unit !== 3'b010) begin errors++; $display("FAIL add_unit got %b exp 010", iss_unit); end
        checks++; if (iss_reg1 !== 6'd2 || iss_reg2 !== 6'd4) begin errors++; $display("FAIL add_regs got %0d,%0d exp 2,4", iss_reg1, iss_reg2); end
        checks++; if (iss_hasimm !== 1'b1 || iss_imm !== 32'sd1) begin errors++; $display("FAIL add_imm got %b/%0d exp 1/1", iss_hasimm, iss_imm); end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL add_retired got %b exp 0", iss_enable); end
    endtask

    task automatic test_drop();
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hE000_0010, 1'b0, 1'b0);
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_empty_slot got %b exp 0", drop_err); end
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL drop_empty_enable got %b exp 0", iss_enable); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", drop_err); end
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL drop_no_entry got %b exp 0", iss_enable); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_single_cycle got %b exp 0", drop_err); end
    endtask

    task automatic test_full();
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom;
            drive(1'b1, {4'hC, r[27:0]}, 1'b0, 1'b0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %b exp 1", i, in_ready); end
            tick();
        end
        r = $urandom;
        drive(1'b1, {4'hC, r[27:0]}, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_blocked got %b exp 0", in_ready); end
        tick();
        drive(1'b1, {4'hD, r[27:0]}, 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_popthrough got %b exp 0", in_ready); end
        checks++; if (head_dat !== exp_head()) begin errors++; $display("FAIL full_head got %h exp %h", head_dat, exp_head()); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_ack got %b exp 1", in_ready); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (head_dat !== exp_head()) begin errors++; $display("FAIL full_order_%0d got %h exp %h", i, head_dat, exp_head()); end
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", iss_enable); end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            drive(1'b1, {4'h8, r[27:0]}, 1'b0, 1'b0);
            tick();
        end
        r = $urandom;
        drive(1'b1, {4'hC, r[27:0]}, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL flush_enable got %b exp 0", iss_enable); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (iss_enable !== 1'b0 || head_dat !== 54'd0) begin errors++; $display("FAIL flush_empty got %b/%h exp 0/0", iss_enable, head_dat); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            checks++; if (in_ready !== m_ready()) begin errors++; bad++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", c, in_ready, m_ready()); end
            checks++; if (iss_enable !== ((m_q.size() > 0) || m_bypass())) begin errors++; bad++; $display("FAIL rand_iss_enable cyc %0d got %b exp %b", c, iss_enable, (m_q.size() > 0) || m_bypass()); end
            checks++; if (head_dat !== exp_head()) begin errors++; bad++; $display("FAIL rand_head cyc %0d got %h exp %h", c, head_dat, exp_head()); end
            checks++; if (drop_err !== m_drop) begin errors++; bad++; $display("FAIL rand_drop_err cyc %0d got %b exp %b", c, drop_err, m_drop); end
            checks++; if (halted !== m_halted) begin errors++; bad++; $display("FAIL rand_halted cyc %0d got %b exp %b", c, halted, m_halted); end
            if (bad > 10) break;
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        for (int i = 0; i < 2; i++) begin
            r = $urandom;
            drive(1'b1, {4'h9, r[27:0]}, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (iss_enable !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midreset_async got %b/%b exp 0/0", iss_enable, in_ready); end
        checks++; if (head_dat !== 54'd0) begin errors++; $display("FAIL midreset_data got %h exp 0", head_dat); end
        m_q.delete();
        m_drop = 1'b0;
        m_halted = 1'b0;
        iss_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL midreset_discard got %b exp 0", iss_enable); end
    endtask

    task automatic test_bypass();
        logic [31:0] r;
        r = $urandom;
        drive(1'b1, {4'h9, r[27:0]}, 1'b1, 1'b0);
`ifdef DECODE_QUEUE_BYPASS_EN
        checks++; if (iss_enable !== 1'b1 || iss_unit !== 3'b011) begin errors++; $display("FAIL bypass_same_cycle got %b/%b exp 1/011", iss_enable, iss_unit); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL bypass_not_enqueued got %b exp 0", iss_enable); end
`else
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle got %b exp 0", iss_enable); end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (iss_enable !== 1'b1 || iss_unit !== 3'b011) begin errors++; $display("FAIL nobypass_next_cycle got %b/%b exp 1/011", iss_enable, iss_unit); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (iss_enable !== 1'b0) begin errors++; $display("FAIL nobypass_retired got %b exp 0", iss_enable); end
`endif
    endtask

    task automatic test_halt();
        drive(1'b1, 32'h1000_0000, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL halt_accept got %b exp 1", in_ready); end
        tick();
        drive(1'b1, 32'hC000_0002, 1'b0, 1'b0);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky_set got %b exp 1", halted); end
        checks++; if (iss_enable !== 1'b1 || iss_unit !== 3'b101) begin errors++; $display("FAIL halt_issue got %b/%b exp 1/101", iss_enable, iss_unit); end
        checks++; if (iss_hasimm !== 1'b0 || iss_imm !== 32'sd0) begin errors++; $display("FAIL halt_imm got %b/%0d exp 0/0", iss_hasimm, iss_imm); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got %b exp 0", in_ready); end
        tick();
        drive(1'b1, 32'hC000_0002, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (iss_enable !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL halt_blocks_input got %b/%b exp 0/0", iss_enable, in_ready); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_survives_flush got %b exp 1", halted); end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_drop();
        test_full();
        test_flush();
        test_random();
        test_reset_mid();
        test_bypass();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
